ppu_vbuf_writer: RTL and testbench

//   Writer end of the double-buffered video buffer (vbuf) that the LCD output stage reads.
//   - Takes the PPU pixel stream, 8-bit HSV per pixel, raster order, 256 pixels per line.
//   - Writes it into vbuf at address {page, y[7:0], x[7:0]}.
//   - Toggles its write page at the end of every PPU frame.
//   - Starts on page 0, so the first frame is written while the LCD reads page 1.

---
 rtl/ppu_vbuf_writer_pkg.sv | 31 +++
 rtl/ppu_vbuf_xy_cnt.sv | 40 ++++
 rtl/ppu_vbuf_writer.sv | 129 ++++++++++++
 tb/tb_ppu_vbuf_writer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_vbuf_writer_pkg.sv
// Shared vbuf definitions: FSM state encoding, address field layout and line width.
// Imported by the PPU writer and the LCD reader stage.
package ppu_vbuf_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FILL   = 2'd2,
    ST_DONE   = 2'd3
  } vbuf_state_t;

  localparam int unsigned VBUF_AW       = 17;
  localparam int unsigned VBUF_PAGE_BIT = 16;
  localparam int unsigned VBUF_Y_MSB    = 15;
  localparam int unsigned VBUF_Y_LSB    = 8;
  localparam int unsigned VBUF_X_MSB    = 7;
  localparam int unsigned VBUF_X_LSB    = 0;
  localparam int unsigned VBUF_LINE_W   = 256;

  function automatic logic [VBUF_AW-1:0] vbuf_addr(input logic page,
                                                   input logic [7:0] y,
                                                   input logic [7:0] x);
    logic [VBUF_AW-1:0] a;
    a                         = '0;
    a[VBUF_PAGE_BIT]          = page;
    a[VBUF_Y_MSB:VBUF_Y_LSB]  = y;
    a[VBUF_X_MSB:VBUF_X_LSB]  = x;
    return a;
  endfunction

endpackage

// File: rtl/ppu_vbuf_xy_cnt.sv
// 8-bit x/y raster counter. Clear and increment may coincide: the count restarts
// at (0,0) and then steps, landing on (1,0).
module ppu_vbuf_xy_cnt (
  input  logic       i_ppu_clk,
  input  logic       i_ppu_rstn,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic       o_x_last,
  output logic       o_y_last
);

  logic [7:0] x_base, y_base, x_nx, y_nx;

  always_comb begin
    x_base = i_clr ? '0 : o_x;
    y_base = i_clr ? '0 : o_y;
    x_nx   = x_base;
    y_nx   = y_base;
    if (i_inc) begin
      x_nx = x_base + 8'd1;
      if (x_base == '1) y_nx = y_base + 8'd1;
    end
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      o_x <= '0;
      o_y <= '0;
    end else begin
      o_x <= x_nx;
      o_y <= y_nx;
    end
  end

  assign o_x_last = (o_x == '1);
  assign o_y_last = (o_y == '1);

endmodule

// File: rtl/ppu_vbuf_writer.sv
// Writer end of the double-buffered vbuf: PPU pixel stream -> {page, y, x} writes.
// Optional macro PPU_VBUF_FILL_EN overwrites rows V_LINES..255 with FILL_HSV each frame.
module ppu_vbuf_writer
  import ppu_vbuf_writer_pkg::*;
#(
  parameter int unsigned V_LINES  = 240,
  parameter logic [7:0]  FILL_HSV = 8'h00
) (
  input  logic               i_ppu_clk,
  input  logic               i_ppu_rstn,
  input  logic               i_pix_vld,
  input  logic               i_pix_sof,
  input  logic [7:0]         i_pix_hsv,
  output logic               o_pix_rdy,
  output logic               o_vbuf_wr,
  output logic [VBUF_AW-1:0] o_vbuf_addr,
  output logic [7:0]         o_vbuf_data,
  output logic               o_wr_page,
  output logic               o_frame_done,
  output logic               o_sync_err,
  input  logic               i_err_clr
);

  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  vbuf_state_t        state, state_nx;
  logic               page;
  logic [7:0]         x, y;
  logic               x_last, y_last;
  logic               cnt_clr, cnt_inc;
  logic               wr_en, err_set, accept;
  logic [VBUF_AW-1:0] wr_addr;
  logic [7:0]         wr_data;

  assign accept = i_pix_vld & o_pix_rdy;

  ppu_vbuf_xy_cnt u_xy_cnt (
    .i_ppu_clk  (i_ppu_clk),
    .i_ppu_rstn (i_ppu_rstn),
    .i_clr      (cnt_clr),
    .i_inc      (cnt_inc),
    .o_x        (x),
    .o_y        (y),
    .o_x_last   (x_last),
    .o_y_last   (y_last)
  );

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    err_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && i_pix_sof) begin
          wr_en    = 1'b1;
          wr_addr  = vbuf_addr(page, 8'd0, 8'd0);
          wr_data  = i_pix_hsv;
          cnt_clr  = 1'b1;
          cnt_inc  = 1'b1;
          state_nx = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = i_pix_hsv;
          cnt_inc = 1'b1;
          // (0,0) is consumed on entry, so any sof seen here is mid-frame
          if (i_pix_sof) begin
            err_set = 1'b1;
            cnt_clr = 1'b1;
            wr_addr = vbuf_addr(page, 8'd0, 8'd0);
          end else begin
            wr_addr = vbuf_addr(page, y, x);
            if (x_last && (y == Y_LAST)) begin
`ifdef PPU_VBUF_FILL_EN
              state_nx = (V_LINES < VBUF_LINE_W) ? ST_FILL : ST_DONE;
`else
              state_nx = ST_DONE;
`endif
            end
          end
        end
      end
      ST_FILL: begin
        wr_en   = 1'b1;
        wr_addr = vbuf_addr(page, y, x);
        wr_data = FILL_HSV;
        cnt_inc = 1'b1;
        if (x_last && y_last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        cnt_clr  = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      state        <= ST_IDLE;
      page         <= 1'b0;
      o_pix_rdy    <= 1'b0;
      o_vbuf_wr    <= 1'b0;
      o_vbuf_addr  <= '0;
      o_vbuf_data  <= '0;
      o_frame_done <= 1'b0;
      o_sync_err   <= 1'b0;
    end else begin
      state        <= state_nx;
      if (state == ST_DONE) page <= ~page;
      // ready and done are registered from the next state so they align with it
      o_pix_rdy    <= (state_nx == ST_IDLE) || (state_nx == ST_ACTIVE);
      o_frame_done <= (state_nx == ST_DONE);
      o_vbuf_wr    <= wr_en;
      o_vbuf_addr  <= wr_addr;
      o_vbuf_data  <= wr_data;
      o_sync_err   <= err_set | (o_sync_err & ~i_err_clr);
    end
  end

  assign o_wr_page = page;

endmodule

// File: tb/tb_ppu_vbuf_writer.sv
// Scoreboard bench for ppu_vbuf_writer: a pixel-index model predicts writes,
// ready, frame_done, page and sync_err; a monitor pops and compares each write.
module tb_ppu_vbuf_writer;
  import ppu_vbuf_writer_pkg::*;

  localparam int unsigned V_LINES  = 16;
  localparam logic [7:0]  FILL_HSV = 8'h3F;
  localparam int unsigned TOTAL    = V_LINES * VBUF_LINE_W;
`ifdef PPU_VBUF_FILL_EN
  localparam int unsigned RND_PIX  = 700;
`else
  localparam int unsigned RND_PIX  = TOTAL + 300;
`endif

  logic        i_ppu_clk, i_ppu_rstn;
  logic        i_pix_vld, i_pix_sof, i_err_clr;
  logic [7:0]  i_pix_hsv;
  logic        o_pix_rdy, o_vbuf_wr, o_wr_page, o_frame_done, o_sync_err;
  logic [16:0] o_vbuf_addr;
  logic [7:0]  o_vbuf_data;

  ppu_vbuf_writer #(.V_LINES(V_LINES), .FILL_HSV(FILL_HSV)) dut (
    .i_ppu_clk    (i_ppu_clk),
    .i_ppu_rstn   (i_ppu_rstn),
    .i_pix_vld    (i_pix_vld),
    .i_pix_sof    (i_pix_sof),
    .i_pix_hsv    (i_pix_hsv),
    .o_pix_rdy    (o_pix_rdy),
    .o_vbuf_wr    (o_vbuf_wr),
    .o_vbuf_addr  (o_vbuf_addr),
    .o_vbuf_data  (o_vbuf_data),
    .o_wr_page    (o_wr_page),
    .o_frame_done (o_frame_done),
    .o_sync_err   (o_sync_err),
    .i_err_clr    (i_err_clr)
  );

  initial begin
    i_ppu_clk = 1'b0;
    forever #5 i_ppu_clk = ~i_ppu_clk;
  end

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    int unsigned stamp;
  } wr_t;

  wr_t         sb[$];
  wr_t         sb_head;
  int unsigned n_cmp = 0, n_bad = 0, cyc_cnt = 0;

  // model: phase 0 idle, 1 active, 2 fill, 3 done
  int unsigned m_phase, m_idx, m_fidx;
  logic        m_page, m_err, m_acc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_cnt);
    end
  endtask

  // Write monitor, sampled 2 time units after each rising edge
  initial forever begin
    @(posedge i_ppu_clk);
    #2;
    cyc_cnt++;
    if (o_vbuf_wr) begin
      if (sb.size() == 0) chk("wr_unexpected", o_vbuf_wr, 1'b0);
      else begin
        sb_head = sb.pop_front();
        chk("wr_addr", o_vbuf_addr, sb_head.addr);
        chk("wr_data", o_vbuf_data, sb_head.data);
        chk("wr_latency", cyc_cnt, sb_head.stamp + 1);
      end
    end else if (sb.size() != 0 && sb[0].stamp + 1 <= cyc_cnt) begin
      chk("wr_missing", o_vbuf_wr, 1'b1);
      void'(sb.pop_front());
    end
  end

  task automatic push(input logic [15:0] yx, input logic [7:0] d);
    sb.push_back('{addr: {m_page, yx}, data: d, stamp: cyc_cnt});
  endtask

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_fidx = 0;
    m_page  = 1'b0; m_err = 1'b0; m_acc = 1'b0;
  endtask

  // One clock: drive after the edge, check and advance the model on the falling edge
  task automatic cyc(input logic v, input logic s, input logic [7:0] d, input logic clr);
    logic mid;
    i_pix_vld = v; i_pix_sof = s; i_pix_hsv = d; i_err_clr = clr;
    @(negedge i_ppu_clk);
    chk("pix_rdy", o_pix_rdy, m_phase < 2);
    chk("frame_done", o_frame_done, m_phase == 3);
    chk("wr_page", o_wr_page, m_page);
    chk("sync_err", o_sync_err, m_err);
    m_acc = v && (m_phase < 2);
    mid   = 1'b0;
    case (m_phase)
      0: if (v && s) begin
        push(16'h0000, d);
        m_idx = 1; m_phase = 1;
      end
      1: if (v) begin
        if (s) begin
          mid = 1'b1;
          push(16'h0000, d);
          m_idx = 1;
        end else begin
          push(m_idx[15:0], d);
          m_idx++;
          if (m_idx == TOTAL) begin
`ifdef PPU_VBUF_FILL_EN
            m_phase = (TOTAL < 65536) ? 2 : 3;
            m_fidx  = TOTAL;
`else
            m_phase = 3;
`endif
          end
        end
      end
      2: begin
        push(m_fidx[15:0], FILL_HSV);
        m_fidx++;
        if (m_fidx == 65536) m_phase = 3;
      end
      default: begin
        m_page  = ~m_page;
        m_phase = 0;
      end
    endcase
    if (mid) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    @(posedge i_ppu_clk);
    #1;
  endtask

  // Hold a pixel with vld=1 until the model says it was accepted
  task automatic send_pix(input logic s, input logic [7:0] d, input logic clr);
    m_acc = 1'b0;
    for (int k = 0; k < 70000 && !m_acc; k++) cyc(1'b1, s, d, clr);
  endtask

  task automatic idle_until_free();
    for (int k = 0; k < 70000 && m_phase != 0; k++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    i_ppu_rstn = 1'b0;
    sb.delete();
    model_reset();
    i_pix_vld = 1'b0; i_pix_sof = 1'b0; i_pix_hsv = '0; i_err_clr = 1'b0;
    @(negedge i_ppu_clk);
    chk("rst_rdy", o_pix_rdy, 1'b0);
    chk("rst_wr", o_vbuf_wr, 1'b0);
    chk("rst_addr", o_vbuf_addr, 17'h0);
    chk("rst_data", o_vbuf_data, 8'h0);
    chk("rst_done", o_frame_done, 1'b0);
    chk("rst_err", o_sync_err, 1'b0);
    chk("rst_page", o_wr_page, 1'b0);
    @(posedge i_ppu_clk); #1;
    @(posedge i_ppu_clk); #1;
    i_ppu_rstn = 1'b1;
    @(posedge i_ppu_clk); #1;
  endtask

  task automatic send_frame(input logic rnd_data);
    logic [15:0] idx;
    logic [7:0]  d;
    for (int unsigned i = 0; i < TOTAL; i++) begin
      idx = i[15:0];
      d   = rnd_data ? 8'($urandom) : (idx[7:0] ^ idx[15:8]);
      send_pix(i == 0, d, 1'b0);
    end
  endtask

  initial begin
    i_ppu_rstn = 1'b0;
    do_reset();

    // sof=0 pixels in idle are discarded
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // frame 1 (x^y), then frame 2 held through DONE with sof asserted
    send_frame(1'b0);
`ifndef PPU_VBUF_FILL_EN
    send_frame(1'b1);
`endif
    idle_until_free();
`ifdef PPU_VBUF_FILL_EN
    chk("page_after_frames", o_wr_page, 1'b1);
`else
    chk("page_after_frames", o_wr_page, 1'b0);
`endif

    // mid-frame sof at (10,5), then sticky error and clear
    for (int unsigned i = 0; i < 5 * 256 + 10; i++) send_pix(i == 0, 8'(i), 1'b0);
    send_pix(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 20; i++) send_pix(1'b0, 8'(i + 100), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    send_pix(1'b1, 8'h5A, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    do_reset();

    // random valid gaps, ending with a reset in the middle of a frame
    for (int unsigned j = 0; j < RND_PIX; j++) begin
      m_acc = 1'b0;
      for (int k = 0; k < 70000 && !m_acc; k++)
        cyc(1'($urandom_range(0, 1)), (j % TOTAL) == 0, 8'($urandom), 1'b0);
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("sb_drain", sb.size(), 0);
    do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
